load_store_unit: RTL and testbench

//  Sits between the datapath and data_memory. Accepts one load/store request
//  at a time over a valid/ready handshake and handles byte, halfword and word

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//  Bridges the datapath to data_memory. Takes one load/store request at a
//  time over valid/ready, supports byte/half/word sizes, sign/zero extends
//  loads and performs sub-word stores as a read-modify-write because the
//  memory always writes a full word. Misaligned or reserved-size requests
//  are answered with resp_err and never touch memory.
//
//  Ports
//   clk, reset                 clock, async active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write/size/signed      request attributes
//   req_address/req_wdata      byte address, right-aligned store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_err        extended load data, error flag
//   mem_address/write_data/en  to data_memory
//   mem_read_data              from data_memory (combinational read)
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for a request, req_ready = 1
//  LOAD  | memory addressed, capture and extend read data
//  READ  | sub-word store: capture current word and merge store data
//  WRITE | single-cycle write strobe with full word
//  RESP  | response presented until resp_ready
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int byte_W = 4,
   parameter int Addr_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [Addr_W-1:0]   req_address,
   input  logic [8*byte_W-1:0] req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [8*byte_W-1:0] resp_rdata,
   output logic                resp_err,
   output logic [Addr_W-1:0]   mem_address,
   output logic [8*byte_W-1:0] mem_write_data,
   output logic                mem_write_en,
   input  logic [8*byte_W-1:0] mem_read_data
);

   localparam int Data_W = 8 * byte_W;
   localparam int Lane_W = $clog2(byte_W);
   localparam int Sh_W   = $clog2(Data_W);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WRITE, S_RESP} state_t;

   state_t      state;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [15:0] wdata_q;

   logic              req_err;
   logic [Sh_W-1:0]   lane_sh;
   logic [Data_W-1:0] rd_shifted;
   logic [Data_W-1:0] load_ext;
   logic [Data_W-1:0] st_mask;
   logic [Data_W-1:0] st_data;
   logic [Data_W-1:0] merged;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_HALF: req_err = req_address[0];
         SZ_WORD: req_err = |req_address[1:0];
         SZ_BYTE: req_err = 1'b0;
         default: req_err = 1'b1;
      endcase
   end

   // mem_address holds the accepted address while in LOAD/READ, so its low
   // bits select the byte lane within the memory word.
   assign lane_sh    = {mem_address[Lane_W-1:0], 3'b000};
   assign rd_shifted = mem_read_data >> lane_sh;

   always_comb begin
      load_ext = rd_shifted;
      case (size_q)
         SZ_BYTE: load_ext = {{(Data_W-8){signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
         SZ_HALF: load_ext = {{(Data_W-16){signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
         default: load_ext = rd_shifted;
      endcase
   end

   always_comb begin
      st_mask = (size_q == SZ_BYTE) ? {{(Data_W-8){1'b0}}, 8'hFF}
                                    : {{(Data_W-16){1'b0}}, 16'hFFFF};
      st_mask = st_mask << lane_sh;
      st_data = {{(Data_W-16){1'b0}}, wdata_q} << lane_sh;
      merged  = (mem_read_data & ~st_mask) | (st_data & st_mask);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_rdata     <= '0;
         resp_err       <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         size_q         <= SZ_BYTE;
         signed_q       <= 1'b0;
         wdata_q        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  wdata_q   <= req_wdata[15:0];
                  req_ready <= 1'b0;
                  if (req_err) begin
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                     resp_valid <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     resp_err    <= 1'b0;
                     mem_address <= req_address;
                     if (!req_write) begin
                        state <= S_LOAD;
                     end else if (req_size == SZ_WORD) begin
                        mem_write_data <= req_wdata;
                        mem_write_en   <= 1'b1;
                        state          <= S_WRITE;
                     end else begin
                        state <= S_READ;
                     end
                  end
               end
            end
            S_LOAD: begin
               resp_rdata <= load_ext;
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
            S_READ: begin
               mem_write_data <= merged;
               mem_write_en   <= 1'b1;
               state          <= S_WRITE;
            end
            S_WRITE: begin
               mem_write_en <= 1'b0;
               resp_rdata   <= '0;
               resp_valid   <= 1'b1;
               state        <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [7:0]  req_address;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_en;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:63];

   int n_chk  = 0;
   int n_pass = 0;

   int          r_lat;
   int          r_pulses;
   int          r_wecyc;
   logic [31:0] r_rdata;
   logic        r_err;

   load_store_unit #(.byte_W(4), .Addr_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_address    (req_address),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write_en   (mem_write_en),
      .mem_read_data  (mem_read_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // data_memory model: word-indexed, combinational read, full-word write
   assign mem_read_data = mem[mem_address[7:2]];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_address[7:2]] <= mem_write_data;
   end

   task automatic chk(input string tag, input logic ok);
      n_chk++;
      if (ok) n_pass++;
      else $error("FAIL %s", tag);
   endtask

   // Present a request, wait for the accept edge, then step cycles
   // (cycle 1 = the period right after the accept edge) until resp_valid.
   task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [7:0] a, input logic [31:0] wd);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_address = a; req_wdata = wd; resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_accept", req_ready === 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      r_lat = -1; r_pulses = 0; r_wecyc = -1;
      for (int c = 1; c <= 10 && r_lat < 0; c++) begin
         if (mem_write_en) begin
            r_pulses++;
            r_wecyc = c;
         end
         if (resp_valid) r_lat = c;
         else begin
            @(posedge clk);
            #1;
         end
      end
      r_rdata = resp_rdata;
      r_err   = resp_err;
   endtask

   task automatic finish_resp();
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_address = 8'h00; req_wdata = 32'h0; resp_ready = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'h0000_0007;   // bytes 0..3 = 07 00 00 00
      mem[1] = 32'h0000_FFFF;   // bytes 4..7 = FF FF 00 00

      #3 reset = 1'b1;
      #1;
      chk("rst_req_ready", req_ready === 1'b1);
      chk("rst_resp_valid", resp_valid === 1'b0);
      chk("rst_resp_rdata", resp_rdata === 32'h0);
      chk("rst_resp_err", resp_err === 1'b0);
      chk("rst_mem_we", mem_write_en === 1'b0);
      chk("rst_mem_addr", mem_address === 8'h00);
      chk("rst_mem_wdata", mem_write_data === 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // load half signed @4
      run(1'b0, 2'b01, 1'b1, 8'h04, 32'h0);
      chk("lh_s4_rdata", r_rdata === 32'hFFFF_FFFF);
      chk("lh_s4_err", r_err === 1'b0);
      chk("lh_s4_lat", r_lat == 2);
      chk("lh_s4_pulses", r_pulses == 0);
      finish_resp();
      chk("post_hs_resp_valid", resp_valid === 1'b0);
      chk("post_hs_req_ready", req_ready === 1'b1);

      run(1'b0, 2'b01, 1'b0, 8'h04, 32'h0);
      chk("lh_u4_rdata", r_rdata === 32'h0000_FFFF);
      finish_resp();

      run(1'b0, 2'b00, 1'b0, 8'h00, 32'h0);
      chk("lb_u0_rdata", r_rdata === 32'h0000_0007);
      chk("lb_u0_lat", r_lat == 2);
      finish_resp();

      // byte store @1, upper store data bits must be ignored
      run(1'b1, 2'b00, 1'b0, 8'h01, 32'hFFFF_FFAB);
      chk("sb1_lat", r_lat == 3);
      chk("sb1_pulses", r_pulses == 1);
      chk("sb1_we_cycle", r_wecyc == 2);
      chk("sb1_rdata", r_rdata === 32'h0);
      chk("sb1_err", r_err === 1'b0);
      finish_resp();
      chk("sb1_mem0", mem[0] === 32'h0000_AB07);

      run(1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
      chk("lw0_rdata", r_rdata === 32'h0000_AB07);
      finish_resp();

      // misaligned word store
      run(1'b1, 2'b10, 1'b0, 8'h02, 32'h1122_3344);
      chk("sw2_err", r_err === 1'b1);
      chk("sw2_lat", r_lat == 1);
      chk("sw2_pulses", r_pulses == 0);
      chk("sw2_rdata", r_rdata === 32'h0);
      finish_resp();
      chk("sw2_mem0_unchanged", mem[0] === 32'h0000_AB07);

      // aligned word store then half store into upper lane
      run(1'b1, 2'b10, 1'b0, 8'h08, 32'hDEAD_BEEF);
      chk("sw8_lat", r_lat == 2);
      chk("sw8_we_cycle", r_wecyc == 1);
      chk("sw8_err", r_err === 1'b0);
      finish_resp();
      chk("sw8_mem2", mem[2] === 32'hDEAD_BEEF);

      run(1'b1, 2'b01, 1'b0, 8'h0A, 32'hAAAA_5678);
      chk("sh10_lat", r_lat == 3);
      chk("sh10_pulses", r_pulses == 1);
      finish_resp();
      chk("sh10_mem2", mem[2] === 32'h5678_BEEF);

      run(1'b0, 2'b01, 1'b1, 8'h0A, 32'h0);
      chk("lh_s10_rdata", r_rdata === 32'h0000_5678);
      finish_resp();
      run(1'b0, 2'b01, 1'b1, 8'h08, 32'h0);
      chk("lh_s8_rdata", r_rdata === 32'hFFFF_BEEF);
      finish_resp();
      run(1'b0, 2'b00, 1'b1, 8'h08, 32'h0);
      chk("lb_s8_rdata", r_rdata === 32'hFFFF_FFEF);
      finish_resp();
      run(1'b0, 2'b00, 1'b0, 8'h0B, 32'h0);
      chk("lb_u11_rdata", r_rdata === 32'h0000_0056);
      finish_resp();

      // reserved size and misaligned half load
      run(1'b0, 2'b11, 1'b0, 8'h00, 32'h0);
      chk("rsv_err", r_err === 1'b1);
      chk("rsv_lat", r_lat == 1);
      finish_resp();
      run(1'b0, 2'b01, 1'b0, 8'h05, 32'h0);
      chk("lh5_err", r_err === 1'b1);
      chk("lh5_rdata", r_rdata === 32'h0);
      finish_resp();

      // back-pressure: response held 5 cycles with a second request waiting
      run(1'b0, 2'b00, 1'b1, 8'h05, 32'h0);
      chk("bp_lat", r_lat == 2);
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_resp_valid", resp_valid === 1'b1);
         chk("bp_rdata", resp_rdata === 32'hFFFF_FFFF);
         chk("bp_err", resp_err === 1'b0);
         chk("bp_req_ready", req_ready === 1'b0);
         chk("bp_we", mem_write_en === 1'b0);
         @(posedge clk);
         #1;
      end
      finish_resp();
      req_valid = 1'b0;
      chk("bp_after_req_ready", req_ready === 1'b1);
      chk("bp_after_resp_valid", resp_valid === 1'b0);

      // reset during READ of a half store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
      req_address = 8'h06; req_wdata = 32'h0000_1234;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("mid_mem_addr", mem_address === 8'h06);
      chk("mid_req_ready", req_ready === 1'b0);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_req_ready", req_ready === 1'b1);
      chk("mid_rst_resp_valid", resp_valid === 1'b0);
      chk("mid_rst_mem_addr", mem_address === 8'h00);
      chk("mid_rst_we", mem_write_en === 1'b0);
      chk("mid_rst_wdata", mem_write_data === 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_no_we", mem_write_en === 1'b0);
      chk("mid_rst_mem1", mem[1] === 32'h0000_FFFF);

      run(1'b0, 2'b01, 1'b0, 8'h04, 32'h0);
      chk("after_rst_rdata", r_rdata === 32'h0000_FFFF);
      chk("after_rst_lat", r_lat == 2);
      finish_resp();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
